// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer for a WIDTH-bit bidirectional rotate register.
// Optional abort input enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             res_valid,
   input  logic             res_ready,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic [WIDTH-1:0]   rot_r, rot_l;

   // Single-step rotations of the working register, bit by bit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign rot_r[gi] = data_q[(gi + 1) % WIDTH];
      assign rot_l[gi] = data_q[(gi + WIDTH - 1) % WIDTH];
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               data_d  = cmd_data;
               cnt_d   = cmd_count;
               dir_d   = cmd_dir;
               state_d = (cmd_count != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            data_d = dir_q ? rot_l : rot_r;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef SHIFT_SEQ_ABORT_EN
      // Abort wins over a same-cycle result handshake; the result is dropped.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         data_d  = '0;
         cnt_d   = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign res_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign res_data  = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=4, CNT_W=3).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_data;
   logic       cmd_dir;
   logic [2:0] cmd_count;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic       busy;
`ifdef SHIFT_SEQ_ABORT_EN
   logic       abort;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_count (cmd_count),
      .res_valid (res_valid),
      .res_ready (res_ready),
`ifdef SHIFT_SEQ_ABORT_EN
      .abort     (abort),
`endif
      .res_data  (res_data),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send_cmd(input logic [3:0] d, input logic dr, input logic [2:0] c);
      check("cmd_ready_pre", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_dir   = dr;
      cmd_count = c;
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("cmd data=%b dir=%0d count=%0d", d, dr, c);
   endtask

   task automatic idle_checks(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      cmd_dir   = 1'b0;
      cmd_count = '0;
      res_ready = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      abort     = 1'b0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_checks("por");
      check("por_res_data", 32'(res_data), 32'h0);

      // Reset mid-SHIFT discards the command.
      send_cmd(4'b0101, 1'b1, 3'd7);
      check("rst_busy_shift", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_checks("rst");
      check("rst_res_data", 32'(res_data), 32'h0);
      res_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      check("rst_no_result", 32'(seen), 32'd0);
      $display("reset mid-shift done");

      // Right rotate by one.
      send_cmd(4'b1001, 1'b0, 3'd1);
      check("rr_valid_e0", 32'(res_valid), 32'd0);
      check("rr_cmd_ready_e0", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check("rr_valid", 32'(res_valid), 32'd1);
      check("rr_data", 32'(res_data), 32'b1100);
      @(negedge clk);
      idle_checks("rr_after");

      // Left rotate by three.
      send_cmd(4'b0011, 1'b1, 3'd3);
      check("rl_load", 32'(res_data), 32'b0011);
      @(negedge clk);
      check("rl_step1", 32'(res_data), 32'b0110);
      check("rl_valid1", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("rl_step2", 32'(res_data), 32'b1100);
      check("rl_valid2", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("rl_valid", 32'(res_valid), 32'd1);
      check("rl_data", 32'(res_data), 32'b1001);
      @(negedge clk);
      idle_checks("rl_after");

      // Zero count goes straight to DONE.
      send_cmd(4'b1010, 1'b0, 3'd0);
      check("c0_valid", 32'(res_valid), 32'd1);
      check("c0_data", 32'(res_data), 32'b1010);
      @(negedge clk);
      idle_checks("c0_after");

      // Full-width count returns the original word after WIDTH steps.
      send_cmd(4'b1110, 1'b0, 3'd4);
      check("c4_step0", 32'(res_data), 32'b1110);
      @(negedge clk);
      check("c4_step1", 32'(res_data), 32'b0111);
      @(negedge clk);
      check("c4_step2", 32'(res_data), 32'b1011);
      @(negedge clk);
      check("c4_step3", 32'(res_data), 32'b1101);
      check("c4_valid3", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("c4_valid", 32'(res_valid), 32'd1);
      check("c4_data", 32'(res_data), 32'b1110);
      @(negedge clk);
      idle_checks("c4_after");

      // Backpressure: result held, new command blocked until handshake.
      res_ready = 1'b0;
      send_cmd(4'b0110, 1'b0, 3'd1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = 4'b1111;
      cmd_dir   = 1'b0;
      cmd_count = 3'd0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_data", 32'(res_data), 32'b0011);
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
      check("bp_hs_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp_new_valid", 32'(res_valid), 32'd1);
      check("bp_new_data", 32'(res_data), 32'b1111);
      $display("cmd data=1111 dir=0 count=0 (queued behind backpressure)");
      @(negedge clk);
      idle_checks("bp_after");

`ifdef SHIFT_SEQ_ABORT_EN
      // Abort on the second SHIFT cycle drops the command.
      send_cmd(4'b0101, 1'b0, 3'd5);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      idle_checks("ab");
      check("ab_data", 32'(res_data), 32'h0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      check("ab_no_result", 32'(seen), 32'd0);
      send_cmd(4'b1001, 1'b0, 3'd1);
      @(negedge clk);
      check("ab_next_valid", 32'(res_valid), 32'd1);
      check("ab_next_data", 32'(res_data), 32'b1100);
      @(negedge clk);
      idle_checks("ab_after");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
